// File: rtl/branch_pred.sv
// Bimodal branch predictor: 2-bit saturating counters indexed by PC, plus
// registered fetch redirect/flush on mispredict and branch statistics.
module branch_pred #(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] fetch_pc_i,
    output logic        pred_taken_o,
    input  logic        ex_valid_i,
    input  logic        ex_is_cond_i,
    input  logic        ex_is_jump_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_pred_taken_i,
    input  logic        branch_taken_i,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic [31:0] br_count_o,
    output logic [31:0] mispred_count_o
);

    logic [1:0]       cnt_q [NUM_ENTRIES];
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             ev;
    logic             upd_cond;
    logic             mispredict;
    logic [31:0]      redirect_pc_d;
    logic             redirect_q;
    logic [31:0]      redirect_pc_q;
    logic [31:0]      br_count_q;
    logic [31:0]      mispred_count_q;
    logic             unused_pc_bits;

    assign fetch_idx = fetch_pc_i[IDX_W+1:2];
    assign ex_idx    = ex_pc_i[IDX_W+1:2];

    assign unused_pc_bits = ^{fetch_pc_i[31:IDX_W+2], fetch_pc_i[1:0],
                              ex_pc_i[31:IDX_W+2], ex_pc_i[1:0]};

    // Read is from the registered array, so a same-index update is not visible until next cycle
    assign pred_taken_o = cnt_q[fetch_idx][1];

    // Instruction in execute during a redirect cycle is wrong-path
    assign ev       = ex_valid_i & ~redirect_q;
    assign upd_cond = ev & ex_is_cond_i & ~ex_is_jump_i;

    always_comb begin
        mispredict    = ev & (ex_is_jump_i |
                              (ex_is_cond_i & (branch_taken_i != ex_pred_taken_i)));
        redirect_pc_d = (branch_taken_i | ex_is_jump_i) ? ex_target_i : ex_pc_i + 32'd4;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                cnt_q[i] <= 2'b01;
            end
        end else if (upd_cond) begin
            if (branch_taken_i) begin
                if (cnt_q[ex_idx] != 2'b11) cnt_q[ex_idx] <= cnt_q[ex_idx] + 2'd1;
            end else begin
                if (cnt_q[ex_idx] != 2'b00) cnt_q[ex_idx] <= cnt_q[ex_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            redirect_q      <= 1'b0;
            redirect_pc_q   <= '0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            redirect_q <= mispredict;
            if (mispredict) begin
                redirect_pc_q   <= redirect_pc_d;
                mispred_count_q <= mispred_count_q + 32'd1;
            end
            if (upd_cond) br_count_q <= br_count_q + 32'd1;
        end
    end

    assign redirect_o      = redirect_q;
    assign flush_o         = redirect_q;
    assign redirect_pc_o   = redirect_pc_q;
    assign br_count_o      = br_count_q;
    assign mispred_count_o = mispred_count_q;

endmodule

// File: tb/tb_branch_pred.sv
// Scoreboard bench for branch_pred: directed scenarios then random traffic,
// checked against a queue-fed behavioural model.
module tb_branch_pred;

    localparam int NUM = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] fetch_pc_i = '0;
    logic        pred_taken_o;
    logic        ex_valid_i = 1'b0;
    logic        ex_is_cond_i = 1'b0;
    logic        ex_is_jump_i = 1'b0;
    logic [31:0] ex_pc_i = '0;
    logic [31:0] ex_target_i = '0;
    logic        ex_pred_taken_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic [31:0] br_count_o;
    logic [31:0] mispred_count_o;

    branch_pred #(.NUM_ENTRIES(NUM)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .fetch_pc_i(fetch_pc_i),
        .pred_taken_o(pred_taken_o), .ex_valid_i(ex_valid_i),
        .ex_is_cond_i(ex_is_cond_i), .ex_is_jump_i(ex_is_jump_i),
        .ex_pc_i(ex_pc_i), .ex_target_i(ex_target_i),
        .ex_pred_taken_i(ex_pred_taken_i), .branch_taken_i(branch_taken_i),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .flush_o(flush_o),
        .br_count_o(br_count_o), .mispred_count_o(mispred_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        pred;
        logic        cur_redir;
        logic [31:0] cur_pc;
        logic [31:0] cur_br;
        logic [31:0] cur_mis;
        logic        nxt_redir;
        logic [31:0] nxt_pc;
        logic [31:0] nxt_br;
        logic [31:0] nxt_mis;
    } exp_t;

    exp_t sb[$];

    int          m_cnt [NUM];
    logic        m_redir;
    logic [31:0] m_pc, m_br, m_mis;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 1;
        m_redir = 1'b0;
        m_pc    = '0;
        m_br    = '0;
        m_mis   = '0;
    endfunction

    // Apply one cycle of stimulus at the falling edge and queue its expected outcome
    task automatic drive(input bit rst, input bit valid, input bit cond, input bit jump,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input bit pt, input bit bt, input logic [31:0] fpc);
        exp_t e;
        bit   ev, mis;
        int   idx;
        @(negedge clk_i);
        rst_ni = rst; ex_valid_i = valid; ex_is_cond_i = cond; ex_is_jump_i = jump;
        ex_pc_i = pc; ex_target_i = tgt; ex_pred_taken_i = pt; branch_taken_i = bt;
        fetch_pc_i = fpc;
        if (!rst) model_reset();
        e.pred      = (m_cnt[(fpc >> 2) % NUM] >= 2);
        e.cur_redir = m_redir; e.cur_pc = m_pc; e.cur_br = m_br; e.cur_mis = m_mis;
        if (rst) begin
            ev  = valid && !m_redir;
            mis = ev && (jump || (cond && (bt != pt)));
            if (ev && cond && !jump) begin
                idx = int'((pc >> 2) % NUM);
                m_br = m_br + 1;
                if (bt) m_cnt[idx] = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
                else    m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
            end
            m_redir = mis;
            if (mis) begin
                m_pc  = (bt || jump) ? tgt : pc + 32'd4;
                m_mis = m_mis + 1;
            end
        end
        e.nxt_redir = m_redir; e.nxt_pc = m_pc; e.nxt_br = m_br; e.nxt_mis = m_mis;
        sb.push_back(e);
    endtask

    task automatic idle(input logic [31:0] fpc);
        drive(1, 0, 0, 0, 32'h0, 32'h0, 0, 0, fpc);
    endtask

    task automatic cond_br(input logic [31:0] pc, input logic [31:0] tgt, input bit pt, input bit bt);
        drive(1, 1, 1, 0, pc, tgt, pt, bt, pc);
    endtask

    // Monitor: combinational/current outputs after the stimulus settles, registered outputs after the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pred_taken", 32'(pred_taken_o), 32'(e.pred));
                chk("redirect_now", 32'(redirect_o), 32'(e.cur_redir));
                chk("flush_now", 32'(flush_o), 32'(e.cur_redir));
                chk("redirect_pc_now", redirect_pc_o, e.cur_pc);
                chk("br_count_now", br_count_o, e.cur_br);
                chk("mispred_count_now", mispred_count_o, e.cur_mis);
                @(posedge clk_i);
                #1;
                chk("redirect", 32'(redirect_o), 32'(e.nxt_redir));
                chk("flush", 32'(flush_o), 32'(e.nxt_redir));
                chk("redirect_pc", redirect_pc_o, e.nxt_pc);
                chk("br_count", br_count_o, e.nxt_br);
                chk("mispred_count", mispred_count_o, e.nxt_mis);
            end
        end
    end

    initial begin
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h104);
        idle(32'h108);
        // Taken branch at 0x100 predicted not-taken
        cond_br(32'h100, 32'h0000_2000, 0, 1);
        idle(32'h100);
        idle(32'h100);
        // Counter walk at 0x40: four taken then three not-taken
        for (int i = 0; i < 4; i++) begin cond_br(32'h40, 32'h800, 1, 1); idle(32'h40); end
        for (int i = 0; i < 3; i++) begin cond_br(32'h40, 32'h800, 0, 0); idle(32'h40); end
        // Fall-through address wraps past the top of memory
        cond_br(32'hFFFF_FFFC, 32'h1234, 1, 0);
        idle(32'hFFFF_FFFC);
        // Branch in the redirect cycle must be ignored
        cond_br(32'h300, 32'h900, 0, 1);
        cond_br(32'h304, 32'hA00, 0, 1);
        idle(32'h304);
        // Same-cycle lookup and update of index 3
        drive(1, 1, 1, 0, 32'h0C, 32'h50, 1, 1, 32'h0C);
        idle(32'h0C);
        // Jump flagged also as cond, then reset during its redirect cycle
        drive(1, 1, 1, 1, 32'h200, 32'h4000, 0, 0, 32'h200);
        drive(0, 1, 1, 0, 32'h204, 32'h10, 0, 1, 32'h200);
        idle(32'h40);
        idle(32'h100);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pc, fpc;
            pc  = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 47)) << 2;
            fpc = ($urandom_range(0, 3) == 0) ? pc : 32'($urandom_range(0, 47)) << 2;
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 5) == 0),
                  pc, $urandom, 1'($urandom), 1'($urandom), fpc);
        end
        repeat (4) @(posedge clk_i);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
